spi_avs_arbiter: RTL and testbench

//  Two-master round-robin arbiter for the single Avalon-MM slave port (avs_s0_*) of the SPI bridge.

---
 rtl/spi_avs_arbiter_if.sv | 23 ++
 rtl/spi_avs_arbiter.sv | 124 ++++++++++++
 tb/tb_spi_avs_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_avs_arbiter_if.sv
// Avalon-MM single-port bus bundle shared by both masters and the bridge slave.
// The master modport drives the request side; the slave modport answers it.
interface spi_avs_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              waitrequest;

  modport master (
    output address, read, write, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, waitrequest
  );
endinterface

// File: rtl/spi_avs_arbiter.sv
// Round-robin arbiter letting two Avalon-MM masters share the SPI bridge slave port,
// one whole transfer per grant, with a watchdog that force-completes stalled transfers.
module spi_avs_arbiter #(
  parameter int              ADDR_W       = 8,
  parameter int              DATA_W       = 32,
  parameter int              TIMEOUT      = 64,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              reset,
  spi_avs_arbiter_if.slave  m0,
  spi_avs_arbiter_if.slave  m1,
  spi_avs_arbiter_if.master avs_s0,
  output logic              timeout_flag,
  input  logic              timeout_clear
);

  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              to_set;
  logic              done;
  logic [DATA_W-1:0] done_data;

  logic              req0, req1;
  logic              g_req, g_rd, g_wr;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;

  assign req0    = m0.read | m0.write;
  assign req1    = m1.read | m1.write;
  assign g_req   = grant_q ? req1 : req0;
  assign g_rd    = grant_q ? m1.read : m0.read;
  assign g_wr    = grant_q ? m1.write : m0.write;
  assign g_addr  = grant_q ? m1.address : m0.address;
  assign g_wdata = grant_q ? m1.writedata : m0.writedata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_q       <= 1'b1;
      wd_q         <= '0;
      timeout_flag <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      if (to_set)
        timeout_flag <= 1'b1;
      else if (timeout_clear)
        timeout_flag <= 1'b0;
    end
  end

  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    last_d           = last_q;
    wd_d             = wd_q;
    to_set           = 1'b0;
    done             = 1'b0;
    done_data        = '0;
    avs_s0.address   = '0;
    avs_s0.read      = 1'b0;
    avs_s0.write     = 1'b0;
    avs_s0.writedata = '0;

    // Outputs hold their reset values while reset is asserted, whatever the state.
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (req0 | req1) begin
            grant_d = (req0 & req1) ? ~last_q : req1;
            wd_d    = '0;
            state_d = BUSY;
          end
        end
        BUSY: begin
          avs_s0.address   = g_addr;
          avs_s0.writedata = g_wdata;
          if (!g_req) begin
            // Master abandoned its request: quietly return without a completion.
            wd_d    = '0;
            state_d = IDLE;
          end else if (!avs_s0.waitrequest) begin
            avs_s0.read  = g_rd;
            avs_s0.write = g_wr;
            done         = 1'b1;
            done_data    = avs_s0.readdata;
            last_d       = grant_q;
            wd_d         = '0;
            state_d      = IDLE;
          end else if (TIMEOUT != 0 && wd_q == WD_W'(TIMEOUT - 1)) begin
            // Strobes withdrawn so the stuck slave never sees the abandoned access.
            done      = 1'b1;
            done_data = TIMEOUT_DATA;
            to_set    = 1'b1;
            last_d    = grant_q;
            wd_d      = '0;
            state_d   = IDLE;
          end else begin
            avs_s0.read  = g_rd;
            avs_s0.write = g_wr;
            wd_d         = wd_q + WD_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign m0.waitrequest = ~(done & ~grant_q);
  assign m0.readdata    = (done & ~grant_q) ? done_data : '0;
  assign m1.waitrequest = ~(done & grant_q);
  assign m1.readdata    = (done & grant_q) ? done_data : '0;

endmodule

// File: tb/tb_spi_avs_arbiter.sv
// Directed per-cycle vector table plus a hand-written watchdog write sequence.
// TIMEOUT is set to 8 so the watchdog fires quickly.
module tb_spi_avs_arbiter;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic reset;
  logic timeout_flag;
  logic timeout_clear;

  always #5 clk = ~clk;

  spi_avs_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_bus ();
  spi_avs_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_bus ();
  spi_avs_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_bus ();

  spi_avs_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(8), .TIMEOUT_DATA(32'hDEADBEEF)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .m0            (m0_bus),
    .m1            (m1_bus),
    .avs_s0        (s_bus),
    .timeout_flag  (timeout_flag),
    .timeout_clear (timeout_clear)
  );

  typedef struct {
    logic        rst;
    logic        m0_rd, m0_wr;
    logic [7:0]  m0_a;
    logic [31:0] m0_d;
    logic        m1_rd, m1_wr;
    logic [7:0]  m1_a;
    logic [31:0] m1_d;
    logic        s_wait;
    logic [31:0] s_rdata;
    logic        clr;
    logic        e_m0_wait;
    logic [31:0] e_m0_rdata;
    logic        e_m1_wait;
    logic [31:0] e_m1_rdata;
    logic        e_rd, e_wr;
    logic [7:0]  e_addr;
    logic [31:0] e_wdata;
    logic        e_flag;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(
    input logic rst,
    input logic m0_rd, input logic m0_wr, input logic [7:0] m0_a, input logic [31:0] m0_d,
    input logic m1_rd, input logic m1_wr, input logic [7:0] m1_a, input logic [31:0] m1_d,
    input logic s_wait, input logic [31:0] s_rdata, input logic clr,
    input logic e_m0_wait, input logic [31:0] e_m0_rdata,
    input logic e_m1_wait, input logic [31:0] e_m1_rdata,
    input logic e_rd, input logic e_wr, input logic [7:0] e_addr, input logic [31:0] e_wdata,
    input logic e_flag);
    vec_t v;
    v.rst = rst; v.m0_rd = m0_rd; v.m0_wr = m0_wr; v.m0_a = m0_a; v.m0_d = m0_d;
    v.m1_rd = m1_rd; v.m1_wr = m1_wr; v.m1_a = m1_a; v.m1_d = m1_d;
    v.s_wait = s_wait; v.s_rdata = s_rdata; v.clr = clr;
    v.e_m0_wait = e_m0_wait; v.e_m0_rdata = e_m0_rdata;
    v.e_m1_wait = e_m1_wait; v.e_m1_rdata = e_m1_rdata;
    v.e_rd = e_rd; v.e_wr = e_wr; v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_flag = e_flag;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset              = v.rst;
    m0_bus.read        = v.m0_rd;
    m0_bus.write       = v.m0_wr;
    m0_bus.address     = v.m0_a;
    m0_bus.writedata   = v.m0_d;
    m1_bus.read        = v.m1_rd;
    m1_bus.write       = v.m1_wr;
    m1_bus.address     = v.m1_a;
    m1_bus.writedata   = v.m1_d;
    s_bus.waitrequest  = v.s_wait;
    s_bus.readdata     = v.s_rdata;
    timeout_clear      = v.clr;
  endtask

  task automatic check_vec(input int i, input vec_t v);
    chk($sformatf("v%0d m0_wait", i),  32'(m0_bus.waitrequest), 32'(v.e_m0_wait));
    chk($sformatf("v%0d m0_rdata", i), m0_bus.readdata,         v.e_m0_rdata);
    chk($sformatf("v%0d m1_wait", i),  32'(m1_bus.waitrequest), 32'(v.e_m1_wait));
    chk($sformatf("v%0d m1_rdata", i), m1_bus.readdata,         v.e_m1_rdata);
    chk($sformatf("v%0d s_read", i),   32'(s_bus.read),         32'(v.e_rd));
    chk($sformatf("v%0d s_write", i),  32'(s_bus.write),        32'(v.e_wr));
    chk($sformatf("v%0d s_addr", i),   32'(s_bus.address),      32'(v.e_addr));
    chk($sformatf("v%0d s_wdata", i),  s_bus.writedata,         v.e_wdata);
    chk($sformatf("v%0d flag", i),     32'(timeout_flag),       32'(v.e_flag));
  endtask

  initial begin
    vec_t idle_v;
    int   n;
    // rst, m0 rd/wr/a/d, m1 rd/wr/a/d, s_wait, s_rdata, clr, exp m0 wait/rdata, m1 wait/rdata, rd, wr, addr, wdata, flag
    // m0 single write, zero-wait slave
    add(1, 0,0,8'h00,0, 0,0,8'h00,0, 0,0,0, 1,0, 1,0, 0,0,8'h00,0, 0);
    add(0, 0,0,8'h00,0, 0,0,8'h00,0, 0,0,0, 1,0, 1,0, 0,0,8'h00,0, 0);
    add(0, 0,1,8'h04,32'hA5, 0,0,8'h00,0, 0,0,0, 1,0, 1,0, 0,0,8'h00,0, 0);
    add(0, 0,1,8'h04,32'hA5, 0,0,8'h00,0, 0,0,0, 0,0, 1,0, 0,1,8'h04,32'hA5, 0);
    add(0, 0,0,8'h00,0, 0,0,8'h00,0, 0,0,0, 1,0, 1,0, 0,0,8'h00,0, 0);
    // both masters read from reset: m0, m1, m0, m1
    add(1, 1,0,8'h20,0, 1,0,8'h30,0, 0,0,0, 1,0, 1,0, 0,0,8'h00,0, 0);
    add(0, 1,0,8'h20,0, 1,0,8'h30,0, 0,32'hA0A0A0A0,0, 1,0, 1,0, 0,0,8'h00,0, 0);
    add(0, 1,0,8'h20,0, 1,0,8'h30,0, 0,32'hA0A0A0A0,0, 0,32'hA0A0A0A0, 1,0, 1,0,8'h20,0, 0);
    add(0, 1,0,8'h20,0, 1,0,8'h30,0, 0,32'hB1B1B1B1,0, 1,0, 1,0, 0,0,8'h00,0, 0);
    add(0, 1,0,8'h20,0, 1,0,8'h30,0, 0,32'hB1B1B1B1,0, 1,0, 0,32'hB1B1B1B1, 1,0,8'h30,0, 0);
    add(0, 1,0,8'h20,0, 1,0,8'h30,0, 0,32'hC2C2C2C2,0, 1,0, 1,0, 0,0,8'h00,0, 0);
    add(0, 1,0,8'h20,0, 1,0,8'h30,0, 0,32'hC2C2C2C2,0, 0,32'hC2C2C2C2, 1,0, 1,0,8'h20,0, 0);
    add(0, 1,0,8'h20,0, 1,0,8'h30,0, 0,32'hD3D3D3D3,0, 1,0, 1,0, 0,0,8'h00,0, 0);
    add(0, 1,0,8'h20,0, 1,0,8'h30,0, 0,32'hD3D3D3D3,0, 1,0, 0,32'hD3D3D3D3, 1,0,8'h30,0, 0);
    add(0, 0,0,8'h00,0, 0,0,8'h00,0, 0,0,0, 1,0, 1,0, 0,0,8'h00,0, 0);
    // m1 read with 3 wait cycles
    add(0, 0,0,8'h00,0, 1,0,8'h10,0, 1,0,0, 1,0, 1,0, 0,0,8'h00,0, 0);
    for (int k = 0; k < 3; k++)
      add(0, 0,0,8'h00,0, 1,0,8'h10,0, 1,0,0, 1,0, 1,0, 1,0,8'h10,0, 0);
    add(0, 0,0,8'h00,0, 1,0,8'h10,0, 0,32'h12345678,0, 1,0, 0,32'h12345678, 1,0,8'h10,0, 0);
    add(0, 0,0,8'h00,0, 0,0,8'h00,0, 0,0,0, 1,0, 1,0, 0,0,8'h00,0, 0);
    // m0 read against a stuck slave: watchdog fires in the 8th busy cycle
    add(0, 1,0,8'h08,0, 0,0,8'h00,0, 1,0,0, 1,0, 1,0, 0,0,8'h00,0, 0);
    for (int k = 0; k < 7; k++)
      add(0, 1,0,8'h08,0, 0,0,8'h00,0, 1,0,0, 1,0, 1,0, 1,0,8'h08,0, 0);
    add(0, 1,0,8'h08,0, 0,0,8'h00,0, 1,0,0, 0,32'hDEADBEEF, 1,0, 0,0,8'h08,0, 0);
    add(0, 0,0,8'h00,0, 0,0,8'h00,0, 0,0,0, 1,0, 1,0, 0,0,8'h00,0, 1);
    add(0, 0,0,8'h00,0, 0,0,8'h00,0, 0,0,1, 1,0, 1,0, 0,0,8'h00,0, 1);
    add(0, 0,0,8'h00,0, 0,0,8'h00,0, 0,0,0, 1,0, 1,0, 0,0,8'h00,0, 0);
    // reset in the middle of a stalled m1 transfer, then contention goes to m0
    add(0, 0,0,8'h00,0, 1,0,8'h3C,0, 1,0,0, 1,0, 1,0, 0,0,8'h00,0, 0);
    add(0, 0,0,8'h00,0, 1,0,8'h3C,0, 1,0,0, 1,0, 1,0, 1,0,8'h3C,0, 0);
    add(1, 1,0,8'h44,0, 1,0,8'h3C,0, 1,0,0, 1,0, 1,0, 0,0,8'h00,0, 0);
    add(0, 1,0,8'h44,0, 1,0,8'h3C,0, 0,32'h55AA55AA,0, 1,0, 1,0, 0,0,8'h00,0, 0);
    add(0, 1,0,8'h44,0, 1,0,8'h3C,0, 0,32'h55AA55AA,0, 0,32'h55AA55AA, 1,0, 1,0,8'h44,0, 0);
    add(0, 0,0,8'h00,0, 1,0,8'h3C,0, 0,32'h0F0F0F0F,0, 1,0, 1,0, 0,0,8'h00,0, 0);
    add(0, 0,0,8'h00,0, 1,0,8'h3C,0, 0,32'h0F0F0F0F,0, 1,0, 0,32'h0F0F0F0F, 1,0,8'h3C,0, 0);
    add(0, 0,0,8'h00,0, 0,0,8'h00,0, 0,0,0, 1,0, 1,0, 0,0,8'h00,0, 0);
    // m0 abandons its read mid-stall; waiting m1 is served next
    add(0, 1,0,8'h50,0, 1,0,8'h60,0, 1,0,0, 1,0, 1,0, 0,0,8'h00,0, 0);
    add(0, 1,0,8'h50,0, 1,0,8'h60,0, 1,0,0, 1,0, 1,0, 1,0,8'h50,0, 0);
    add(0, 0,0,8'h50,0, 1,0,8'h60,0, 1,0,0, 1,0, 1,0, 0,0,8'h50,0, 0);
    add(0, 0,0,8'h00,0, 1,0,8'h60,0, 0,32'h77777777,0, 1,0, 1,0, 0,0,8'h00,0, 0);
    add(0, 0,0,8'h00,0, 1,0,8'h60,0, 0,32'h77777777,0, 1,0, 0,32'h77777777, 1,0,8'h60,0, 0);
    add(0, 0,0,8'h00,0, 0,0,8'h00,0, 0,0,0, 1,0, 1,0, 0,0,8'h00,0, 0);

    idle_v = vecs[0];
    drive(idle_v);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(negedge clk);
      check_vec(i, vecs[i]);
      @(posedge clk);
      #1;
    end

    // Stalled m1 write: watchdog drops the write strobe, and its flag set beats a simultaneous clear.
    m1_bus.write      = 1'b1;
    m1_bus.address    = 8'h70;
    m1_bus.writedata  = 32'hCAFEF00D;
    s_bus.waitrequest = 1'b1;
    timeout_clear     = 1'b1;
    @(posedge clk);
    #1;
    n = 1;
    while (n <= 20) begin
      @(negedge clk);
      if (m1_bus.waitrequest == 1'b0) break;
      chk($sformatf("wr stall%0d s_write", n), 32'(s_bus.write), 32'd1);
      @(posedge clk);
      #1;
      n++;
    end
    chk("wr timeout cycle", 32'(n), 32'd8);
    chk("wr timeout s_write", 32'(s_bus.write), 32'd0);
    chk("wr timeout m1_rdata", m1_bus.readdata, 32'hDEADBEEF);
    @(posedge clk);
    #1;
    m1_bus.write  = 1'b0;
    timeout_clear = 1'b0;
    @(negedge clk);
    chk("flag set over clear", 32'(timeout_flag), 32'd1);
    @(posedge clk);
    #1;
    timeout_clear = 1'b1;
    @(posedge clk);
    #1;
    timeout_clear = 1'b0;
    @(negedge clk);
    chk("flag cleared", 32'(timeout_flag), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
